// File: rtl/mem_wb_stage_pkg.sv
// Shared RV32I memory/write-back definitions: mem op codes, funct3 widths,
// and the stage FSM encoding.
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_t;

  // Unknown funct3 codes fall back to a full word.
  function automatic size_t f3_size(input logic [2:0] f3);
    size_t s;
    s = SZ_W;
    unique case (1'b1)
      (f3 == F3_B) || (f3 == F3_BU): s = SZ_B;
      (f3 == F3_H) || (f3 == F3_HU): s = SZ_H;
      default:                       s = SZ_W;
    endcase
    return s;
  endfunction

  function automatic logic misaligned(
    input size_t      sz,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    unique case (sz)
      SZ_H:    m = off[0];
      SZ_W:    m = (off != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX-side issue bus, data-memory port and register-file write port
// of the memory/write-back stage.
interface mem_wb_stage_if;
  import core_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_alu;
  logic [XLEN-1:0] in_sd;
  logic [4:0]      in_wa;
  logic            in_we;
  logic [1:0]      in_mem;
  logic [2:0]      in_f3;

  logic            dmem_req_valid;
  logic            dmem_req_ready;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [3:0]      dmem_wstrb;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_rsp_valid;
  logic [XLEN-1:0] dmem_rsp_rdata;

  logic            rf_we;
  logic [4:0]      rf_wa;
  logic [XLEN-1:0] rf_wd;
  logic            misalign;

  modport master (
    output in_valid, in_alu, in_sd, in_wa,
    output in_we, in_mem, in_f3,
    input  in_ready,
    input  dmem_req_valid, dmem_we,
    input  dmem_addr, dmem_wstrb, dmem_wdata,
    output dmem_req_ready,
    output dmem_rsp_valid, dmem_rsp_rdata,
    input  rf_we, rf_wa, rf_wd, misalign
  );

  modport slave (
    input  in_valid, in_alu, in_sd, in_wa,
    input  in_we, in_mem, in_f3,
    output in_ready,
    output dmem_req_valid, dmem_we,
    output dmem_addr, dmem_wstrb, dmem_wdata,
    input  dmem_req_ready,
    input  dmem_rsp_valid, dmem_rsp_rdata,
    output rf_we, rf_wa, rf_wd, misalign
  );

endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Load data alignment: picks the byte/half lane from the memory word
// and sign- or zero-extends it according to funct3.
module load_align
  import core_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      f3,
  output logic [XLEN-1:0] result
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        sx;

  always_comb begin
    b      = rdata[{off, 3'b000} +: 8];
    h      = off[1] ? rdata[31:16] : rdata[15:0];
    sx     = !f3[2];
    result = rdata;
    unique case (f3_size(f3))
      SZ_B:    result = {{24{sx & b[7]}}, b};
      SZ_H:    result = {{16{sx & h[15]}}, h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: dmem load/store handshake,
// load alignment and registered register-file write port.
module mem_wb_stage
  import core_pkg::*;
(
  input logic           clk,
  input logic           rst,
  mem_wb_stage_if.slave bus
);

  state_t          state;
  logic [1:0]      off;
  logic [2:0]      f3;
  logic [4:0]      wa;
  logic            req_valid;
  logic            we_q;
  logic [XLEN-1:0] addr;
  logic [3:0]      wstrb;
  logic [XLEN-1:0] wdata;
  logic            rf_we;
  logic [4:0]      rf_wa;
  logic [XLEN-1:0] rf_wd;
  logic            mis_q;
  logic [XLEN-1:0] ld_data;

  size_t           sz;
  logic            mis;
  logic            is_mem;
  logic            is_st;
  logic [3:0]      st_strb;
  logic [XLEN-1:0] st_data;

  assign sz     = f3_size(bus.in_f3);
  assign mis    = misaligned(sz, bus.in_alu[1:0]);
  assign is_st  = (bus.in_mem == MEM_STORE);
  assign is_mem = (bus.in_mem == MEM_LOAD) || is_st;

  always_comb begin
    st_strb = 4'b1111;
    st_data = bus.in_sd;
    unique case (sz)
      SZ_B: begin
        st_strb = 4'b0001 << bus.in_alu[1:0];
        st_data = {4{bus.in_sd[7:0]}};
      end
      SZ_H: begin
        st_strb = 4'b0011 << {bus.in_alu[1], 1'b0};
        st_data = {2{bus.in_sd[15:0]}};
      end
      default: ;
    endcase
  end

  load_align u_align (
    .rdata  (bus.dmem_rsp_rdata),
    .off    (off),
    .f3     (f3),
    .result (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      off       <= '0;
      f3        <= '0;
      wa        <= '0;
      req_valid <= 1'b0;
      we_q      <= 1'b0;
      addr      <= '0;
      wstrb     <= '0;
      wdata     <= '0;
      rf_we     <= 1'b0;
      rf_wa     <= '0;
      rf_wd     <= '0;
      mis_q     <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      mis_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.in_valid && !is_mem) begin
            rf_we <= bus.in_we && (bus.in_wa != 5'd0);
            rf_wa <= bus.in_wa;
            rf_wd <= bus.in_alu;
          end else if (bus.in_valid) begin
            off <= bus.in_alu[1:0];
            f3  <= bus.in_f3;
            wa  <= bus.in_wa;
            if (mis) begin
              mis_q <= 1'b1;
            end else begin
              state     <= REQ;
              req_valid <= 1'b1;
              we_q      <= is_st;
              addr      <= {bus.in_alu[31:2], 2'b00};
              wstrb     <= is_st ? st_strb : 4'b0000;
              wdata     <= st_data;
            end
          end
        end
        REQ: begin
          if (bus.dmem_req_ready) begin
            req_valid <= 1'b0;
            we_q      <= 1'b0;
            wstrb     <= 4'b0000;
            state     <= we_q ? IDLE : RESP;
          end
        end
        RESP: begin
          if (bus.dmem_rsp_valid) begin
            rf_we <= (wa != 5'd0);
            rf_wa <= wa;
            rf_wd <= ld_data;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready       = (state == IDLE) && !rst;
  assign bus.dmem_req_valid = req_valid;
  assign bus.dmem_we        = we_q;
  assign bus.dmem_addr      = addr;
  assign bus.dmem_wstrb     = wstrb;
  assign bus.dmem_wdata     = wdata;
  assign bus.rf_we          = rf_we;
  assign bus.rf_wa          = rf_wa;
  assign bus.rf_wd          = rf_wd;
  assign bus.misalign       = mis_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a cycle-indexed expectation model
// and an every-cycle output compare.
module tb_mem_wb_stage;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_wb_stage_if bus();

  mem_wb_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit cmp_on = 1'b0;

  logic [36:0] wb_at [int];
  bit          mis_at [int];

  logic        exp_ready;
  logic        exp_req;
  logic        exp_we;
  logic [31:0] exp_addr;
  logic [3:0]  exp_wstrb;
  logic [31:0] exp_wdata;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic int unsigned nbytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdata,
                                         input logic [31:0] a,
                                         input logic [2:0] f3);
    logic [31:0] s;
    logic [31:0] v;
    s = rdata >> (8 * (a % 4));
    case (f3)
      3'b000: begin
        v = s & 32'hFF;
        if (v >= 128) v = v + 32'hFFFF_FF00;
      end
      3'b100: v = s & 32'hFF;
      3'b001: begin
        v = s & 32'hFFFF;
        if (v >= 32768) v = v + 32'hFFFF_0000;
      end
      3'b101: v = s & 32'hFFFF;
      default: v = rdata;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] m_strb(input logic [31:0] a,
                                        input logic [2:0] f3);
    int unsigned m;
    m = ((1 << nbytes(f3)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] sd,
                                          input logic [2:0] f3);
    case (nbytes(f3))
      1:       return (sd & 32'hFF) * 32'h0101_0101;
      2:       return (sd & 32'hFFFF) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    bus.in_valid       = 1'b0;
    bus.in_mem         = MEM_NONE;
    bus.dmem_req_ready = 1'b0;
    bus.dmem_rsp_valid = 1'b0;
    bus.dmem_rsp_rdata = $urandom;
    exp_ready          = 1'b1;
    exp_req            = 1'b0;
  endtask

  task automatic set_req(input logic [31:0] a, input logic w,
                         input logic [3:0] s, input logic [31:0] d);
    exp_ready = 1'b0;
    exp_req   = 1'b1;
    exp_addr  = a;
    exp_we    = w;
    exp_wstrb = s;
    exp_wdata = d;
  endtask

  task automatic issue_alu(input logic [31:0] alu, input logic [4:0] wa,
                           input logic we);
    bus.in_valid = 1'b1;
    bus.in_mem   = MEM_NONE;
    bus.in_alu   = alu;
    bus.in_sd    = $urandom;
    bus.in_wa    = wa;
    bus.in_we    = we;
    bus.in_f3    = 3'($urandom);
    if (we && wa != 0) wb_at[cyc + 1] = {wa, alu};
  endtask

  task automatic do_mem(
    input logic [1:0]  kind,
    input logic [31:0] alu,
    input logic [31:0] sd,
    input logic [2:0]  f3,
    input logic [4:0]  wa,
    input logic [31:0] rdata,
    input int          req_wait,
    input int          rsp_wait,
    input bit          lit,
    input logic [31:0] lit_wd,
    input logic [3:0]  lit_strb,
    input logic [31:0] lit_wdata
  );
    logic [31:0] wd;
    logic [31:0] wdat;
    logic [3:0]  strb;
    logic        st;
    st   = (kind == MEM_STORE);
    wd   = m_load(rdata, alu, f3);
    strb = st ? m_strb(alu, f3) : 4'b0000;
    wdat = m_wdata(sd, f3);
    if (lit && !st) begin
      chk("model_load", wd, lit_wd);
      wd = lit_wd;
    end
    if (lit && st) begin
      chk("model_wstrb", 32'(strb), 32'(lit_strb));
      chk("model_wdata", wdat, lit_wdata);
      strb = lit_strb;
      wdat = lit_wdata;
    end
    bus.in_valid = 1'b1;
    bus.in_mem   = kind;
    bus.in_alu   = alu;
    bus.in_sd    = sd;
    bus.in_f3    = f3;
    bus.in_wa    = wa;
    bus.in_we    = 1'b1;
    if ((alu % nbytes(f3)) != 0) begin
      mis_at[cyc + 1] = 1'b1;
      tick();
      return;
    end
    tick();
    set_req(alu - (alu % 4), st, strb, wdat);
    for (int i = 0; i < req_wait; i++) begin
      bus.dmem_rsp_valid = 1'b1;
      tick();
      set_req(alu - (alu % 4), st, strb, wdat);
    end
    bus.dmem_req_ready = 1'b1;
    tick();
    if (st) return;
    exp_ready = 1'b0;
    for (int i = 0; i < rsp_wait; i++) begin
      bus.dmem_req_ready = 1'b1;
      tick();
      exp_ready = 1'b0;
    end
    bus.dmem_rsp_valid = 1'b1;
    bus.dmem_rsp_rdata = rdata;
    if (wa != 0) wb_at[cyc + 1] = {wa, wd};
    tick();
  endtask

  task automatic check_reset();
    chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst_rf_wa", 32'(bus.rf_wa), 32'd0);
    chk("rst_rf_wd", bus.rf_wd, 32'd0);
    chk("rst_req_valid", 32'(bus.dmem_req_valid), 32'd0);
    chk("rst_dmem_we", 32'(bus.dmem_we), 32'd0);
    chk("rst_wstrb", 32'(bus.dmem_wstrb), 32'd0);
    chk("rst_misalign", 32'(bus.misalign), 32'd0);
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("in_ready", 32'(bus.in_ready), 32'(exp_ready && !rst));
      chk("rf_we", 32'(bus.rf_we), 32'(wb_at.exists(cyc)));
      if (wb_at.exists(cyc)) begin
        chk("rf_wa", 32'(bus.rf_wa), 32'(wb_at[cyc][36:32]));
        chk("rf_wd", bus.rf_wd, wb_at[cyc][31:0]);
      end
      chk("misalign", 32'(bus.misalign), 32'(mis_at.exists(cyc)));
      chk("req_valid", 32'(bus.dmem_req_valid), 32'(exp_req));
      if (exp_req) begin
        chk("dmem_addr", bus.dmem_addr, exp_addr);
        chk("dmem_we", 32'(bus.dmem_we), 32'(exp_we));
        chk("dmem_wstrb", 32'(bus.dmem_wstrb), 32'(exp_wstrb));
        chk("dmem_wdata", bus.dmem_wdata, exp_wdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    bus.in_valid       = 1'b0;
    bus.in_alu         = '0;
    bus.in_sd          = '0;
    bus.in_wa          = '0;
    bus.in_we          = 1'b0;
    bus.in_mem         = MEM_NONE;
    bus.in_f3          = '0;
    bus.dmem_req_ready = 1'b0;
    bus.dmem_rsp_valid = 1'b0;
    bus.dmem_rsp_rdata = '0;
    exp_ready = 1'b1;
    exp_req   = 1'b0;
    exp_we    = 1'b0;
    exp_addr  = '0;
    exp_wstrb = '0;
    exp_wdata = '0;

    rst = 1'b1;
    tick();
    tick();
    check_reset();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    cmp_on = 1'b1;

    issue_alu(32'h1234, 5'd5, 1'b1);
    tick();
    issue_alu(32'h5555, 5'd0, 1'b1);
    tick();
    issue_alu(32'h0BAD, 5'd9, 1'b0);
    tick();
    issue_alu(32'hA1, 5'd1, 1'b1);
    tick();
    issue_alu(32'hA2, 5'd2, 1'b1);
    tick();
    issue_alu(32'hA3, 5'd31, 1'b1);
    tick();
    tick();

    do_mem(MEM_LOAD, 32'h1003, 0, F3_B, 5'd3, 32'h80FF_0000, 0, 1,
           1, 32'hFFFF_FF80, 4'h0, 0);
    do_mem(MEM_LOAD, 32'h1003, 0, F3_BU, 5'd4, 32'h80FF_0000, 0, 0,
           1, 32'h0000_0080, 4'h0, 0);
    do_mem(MEM_LOAD, 32'h0002, 0, F3_HU, 5'd6, 32'h80FF_0000, 1, 0,
           1, 32'h0000_80FF, 4'h0, 0);
    do_mem(MEM_LOAD, 32'h0000, 0, F3_H, 5'd7, 32'h0000_8001, 0, 0,
           1, 32'hFFFF_8001, 4'h0, 0);
    do_mem(MEM_LOAD, 32'h2004, 0, F3_W, 5'd8, 32'hDEAD_BEEF, 0, 0,
           0, 0, 4'h0, 0);
    do_mem(MEM_LOAD, 32'h2001, 0, F3_B, 5'd10, 32'h1234_7F56, 0, 0,
           0, 0, 4'h0, 0);

    do_mem(MEM_STORE, 32'h2001, 32'h0000_00AB, F3_B, 5'd11, 0, 0, 0,
           1, 0, 4'b0010, 32'hABAB_ABAB);
    do_mem(MEM_STORE, 32'h2002, 32'h1234_CAFE, F3_H, 5'd12, 0, 1, 0,
           1, 0, 4'b1100, 32'hCAFE_CAFE);
    do_mem(MEM_STORE, 32'h2008, 32'h0102_0304, F3_W, 5'd13, 0, 0, 0,
           1, 0, 4'b1111, 32'h0102_0304);
    tick();

    do_mem(MEM_LOAD, 32'h3000, 0, F3_W, 5'd14, 32'hCAFE_F00D, 3, 2,
           0, 0, 4'h0, 0);
    do_mem(MEM_STORE, 32'h3005, 32'h55, F3_B, 5'd0, 0, 3, 0,
           0, 0, 4'h0, 0);

    do_mem(MEM_LOAD, 32'h2002, 0, F3_W, 5'd15, 32'h1111_1111, 0, 0,
           0, 0, 4'h0, 0);
    issue_alu(32'h0077, 5'd16, 1'b1);
    tick();
    do_mem(MEM_STORE, 32'h2001, 32'hFFFF, F3_H, 5'd0, 0, 0, 0,
           0, 0, 4'h0, 0);
    do_mem(MEM_LOAD, 32'h2001, 0, 3'b011, 5'd17, 32'h2222_2222, 0, 0,
           0, 0, 4'h0, 0);
    do_mem(MEM_LOAD, 32'h2004, 0, 3'b011, 5'd18, 32'h8000_0001, 0, 1,
           1, 32'h8000_0001, 4'h0, 0);
    do_mem(MEM_LOAD, 32'h2008, 0, F3_W, 5'd0, 32'h3333_3333, 0, 0,
           0, 0, 4'h0, 0);

    bus.in_valid = 1'b1;
    bus.in_mem   = MEM_LOAD;
    bus.in_alu   = 32'h4000;
    bus.in_sd    = '0;
    bus.in_f3    = F3_W;
    bus.in_wa    = 5'd7;
    bus.in_we    = 1'b1;
    tick();
    set_req(32'h4000, 1'b0, 4'b0000, '0);
    bus.dmem_req_ready = 1'b1;
    tick();
    exp_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.dmem_rsp_valid = 1'b1;
    bus.dmem_rsp_rdata = 32'h4444_4444;
    check_reset();
    tick();
    tick();
    issue_alu(32'h0099, 5'd20, 1'b1);
    tick();
    tick();
    tick();

    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
